// File: rtl/ibex_mem_bus_arbiter.sv
// Merges Ibex instruction-fetch and LSU bus ports onto one shared memory port,
// routing responses back by a source-ID FIFO. Optional: IBEX_ARB_STALL_CNT_EN.
module ibex_mem_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [38:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [38:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [38:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [38:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [38:0] mem_rdata_i,
  input  logic        mem_err_i,
`ifdef IBEX_ARB_STALL_CNT_EN
  output logic [15:0] instr_stall_cnt_o,
`endif
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = $clog2(MaxOutstanding);

  typedef enum logic {
    SrcInstr = 1'b0,
    SrcData  = 1'b1
  } src_e;

  src_e          sel;
  src_e          rr_q, rr_d;
  src_e          lock_sel_q, lock_sel_d;
  logic          lock_q, lock_d;
  src_e          fifo_q [MaxOutstanding];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_req, both_req, full, push, pop;
  src_e          head;

  assign any_req  = instr_req_i | data_req_i;
  assign both_req = instr_req_i & data_req_i;
  assign full     = (cnt_q == CW'(MaxOutstanding));
  assign head     = fifo_q[rd_q];

  always_comb begin
    sel = SrcInstr;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (both_req) begin
      sel = RoundRobin ? rr_q : SrcData;
    end else if (data_req_i) begin
      sel = SrcData;
    end
  end

  assign mem_req_o   = any_req & ~full;
  assign instr_gnt_o = mem_gnt_i & mem_req_o & (sel == SrcInstr);
  assign data_gnt_o  = mem_gnt_i & mem_req_o & (sel == SrcData);
  assign push        = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & (cnt_q != '0);

  // Attributes are gated by any_req so the port stays all-zero while idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (any_req) begin
      if (sel == SrcData) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  // Lock survives a full stall; it is dropped only on grant or when idle.
  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    rr_d       = rr_q;
    if (mem_req_o && !mem_gnt_i) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end else if (push) begin
      lock_d = 1'b0;
    end else if (!full && !any_req) begin
      lock_d = 1'b0;
    end
    if (push && both_req) begin
      rr_d = (sel == SrcData) ? SrcInstr : SrcData;
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = (wr_q == PW'(MaxOutstanding - 1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == PW'(MaxOutstanding - 1)) ? '0 : rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= SrcInstr;
      rr_q       <= SrcData;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= SrcInstr;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      if (push) fifo_q[wr_q] <= sel;
    end
  end

  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_rvalid_o = pop & (head == SrcInstr);
  assign data_rvalid_o  = pop & (head == SrcData);
  assign instr_err_o    = pop & (head == SrcInstr) & mem_err_i;
  assign data_err_o     = pop & (head == SrcData) & mem_err_i;
  assign busy_o         = any_req | (cnt_q != '0);

`ifdef IBEX_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (instr_req_i && !instr_gnt_o && data_gnt_o && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
  assign instr_stall_cnt_o = stall_cnt_q;
`endif

  spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && cnt_q == '0))
    else $warning("arbiter: response with no outstanding transaction dropped");

endmodule

// File: tb/tb_ibex_mem_bus_arbiter.sv
// Scoreboard bench for ibex_mem_bus_arbiter: expected response routing is
// queued at grant time and compared when the response is driven.
module tb_ibex_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i;
  logic [38:0] instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [38:0] data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [38:0] mem_wdata_o, mem_rdata_i;
  logic        busy_o;
`ifdef IBEX_ARB_STALL_CNT_EN
  logic [15:0] instr_stall_cnt_o;
`endif

  typedef struct {
    logic        src;   // 0 = instr, 1 = data
    logic [38:0] data;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  ibex_mem_bus_arbiter #(.MaxOutstanding(4), .RoundRobin(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
`ifdef IBEX_ARB_STALL_CNT_EN
    .instr_stall_cnt_o(instr_stall_cnt_o),
`endif
    .busy_o(busy_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
  endtask

  // Drive one response from the scoreboard head and check its routing.
  task automatic respond(input logic err, input string tag);
    resp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: scoreboard entries got 0 required >=1", tag);
      return;
    end
    e = sb.pop_front();
    mem_rvalid_i = 1; mem_err_i = err; mem_rdata_i = e.data;
    #1;
    if ({instr_rvalid_o, data_rvalid_o} !== (e.src ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL %s_route: {instr,data}_rvalid got %b required %b", tag,
               {instr_rvalid_o, data_rvalid_o}, (e.src ? 2'b01 : 2'b10));
    end
    checks++;
    if ((e.src ? data_rdata_o : instr_rdata_o) !== e.data) begin
      errors++;
      $display("FAIL %s_rdata: got %h required %h", tag,
               (e.src ? data_rdata_o : instr_rdata_o), e.data);
    end
    checks++;
    if ({instr_err_o, data_err_o} !== (err ? (e.src ? 2'b01 : 2'b10) : 2'b00)) begin
      errors++;
      $display("FAIL %s_err: {instr,data}_err got %b required %b", tag,
               {instr_err_o, data_err_o}, (err ? (e.src ? 2'b01 : 2'b10) : 2'b00));
    end
    next_cycle();
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    #12;
    checks++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o, mem_we_o} !== 7'b0
        || mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b gnt=%b%b rv=%b%b busy=%b be=%h addr=%h required all 0",
               mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o,
               mem_be_o, mem_addr_o);
    end
    @(posedge clk); #1;
    rst_ni = 1;
    next_cycle();
    checks++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b req=%b required 0 0", busy_o, mem_req_o);
    end
  endtask

  task automatic test_single_fetch();
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_be_o !== 4'hF || mem_addr_o !== 32'h100
        || mem_we_o !== 1'b0 || mem_wdata_o !== 39'h0) begin
      errors++;
      $display("FAIL fetch_req: gnt=%b%b be=%h addr=%h we=%b wdata=%h required 10 f 100 0 0",
               instr_gnt_o, data_gnt_o, mem_be_o, mem_addr_o, mem_we_o, mem_wdata_o);
    end
    sb.push_back('{src: 1'b0, data: 39'h13});
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_busy: got %b required 1", busy_o);
    end
    next_cycle();
    respond(1'b0, "fetch");
  endtask

  task automatic test_contention();
    logic exp_src = 1'b1;
    instr_req_i = 1; instr_addr_i = 32'h200;
    data_req_i = 1; data_addr_i = 32'h300; data_be_i = 4'h3; data_we_i = 0;
    mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({instr_gnt_o, data_gnt_o} !== (exp_src ? 2'b01 : 2'b10)
          || mem_addr_o !== (exp_src ? 32'h300 : 32'h200)
          || mem_be_o !== (exp_src ? 4'h3 : 4'hF)) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b%b addr=%h be=%h required src=%b", i,
                 instr_gnt_o, data_gnt_o, mem_addr_o, mem_be_o, exp_src);
      end
      sb.push_back('{src: exp_src, data: 39'(32'hA0 + i)});
      exp_src = ~exp_src;
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) respond(1'b0, "rr_resp");
  endtask

  task automatic test_lock();
    data_req_i = 1; data_addr_i = 32'h400; data_be_i = 4'hF; mem_gnt_i = 0;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin instr_req_i = 1; instr_addr_i = 32'h404; end
      if (c == 3) mem_gnt_i = 1;
      #1;
      checks++;
      if (mem_addr_o !== 32'h400 || instr_gnt_o !== 1'b0 || data_gnt_o !== (c == 3)) begin
        errors++;
        $display("FAIL lock_c%0d: addr=%h gnt=%b%b required 400 0%b", c, mem_addr_o,
                 instr_gnt_o, data_gnt_o, (c == 3));
      end
      next_cycle();
    end
    sb.push_back('{src: 1'b1, data: 39'h41});
    data_req_i = 0;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_addr_o !== 32'h404) begin
      errors++;
      $display("FAIL lock_instr: gnt=%b%b addr=%h required 10 404", instr_gnt_o, data_gnt_o,
               mem_addr_o);
    end
    sb.push_back('{src: 1'b0, data: 39'h42});
    next_cycle();
    idle_inputs();
    respond(1'b0, "lock_resp");
    respond(1'b0, "lock_resp");
  endtask

  task automatic test_full();
    resp_t e;
    instr_req_i = 1; instr_addr_i = 32'h600; mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (instr_gnt_o !== 1'b1) begin
        errors++;
        $display("FAIL full_fill%0d: instr_gnt got %b required 1", i, instr_gnt_o);
      end
      sb.push_back('{src: 1'b0, data: 39'(32'h60 + i)});
      next_cycle();
    end
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_block: req=%b gnt=%b busy=%b required 0 0 1", mem_req_o,
               instr_gnt_o, busy_o);
    end
    next_cycle();
    e = sb.pop_front();
    mem_rvalid_i = 1; mem_rdata_i = e.data;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b1 || instr_rdata_o !== e.data) begin
      errors++;
      $display("FAIL full_pop: req=%b rvalid=%b rdata=%h required 0 1 %h", mem_req_o,
               instr_rvalid_o, instr_rdata_o, e.data);
    end
    next_cycle();
    mem_rvalid_i = 0; mem_rdata_i = '0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL full_resume: req=%b gnt=%b required 1 1", mem_req_o, instr_gnt_o);
    end
    sb.push_back('{src: 1'b0, data: 39'h64});
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) respond(1'b0, "full_resp");
  endtask

  task automatic test_error();
    data_req_i = 1; data_addr_i = 32'h500; data_we_i = 0; data_be_i = 4'hF; mem_gnt_i = 1;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL err_gnt: data_gnt got %b required 1", data_gnt_o);
    end
    sb.push_back('{src: 1'b1, data: 39'h7F_DEAD_BEEF});
    next_cycle();
    idle_inputs();
    respond(1'b1, "err");
  endtask

  task automatic test_reset_midflight();
    instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1;
    next_cycle();
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b required 1", busy_o);
    end
    rst_ni = 0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b req=%b required 0 0", busy_o, mem_req_o);
    end
    next_cycle();
    rst_ni = 1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 39'h77;
      #1;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin
        errors++;
        $display("FAIL mid_spurious%0d: rvalid=%b%b busy=%b required 000", i,
                 instr_rvalid_o, data_rvalid_o, busy_o);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_error();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: entries left got %0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
